// File: rtl/reqrsp_bank_tracker_pkg.sv
// Shared definitions for the per-bank response-routing stage of the request/response crossbar.
package reqrsp_bank_tracker_pkg;

  localparam int unsigned DefaultMaxOutstanding = 4;

  // A one-requester crossbar still needs a 1-bit index so the type stays legal.
  function automatic int unsigned idx_width(int unsigned num_inp);
    return (num_inp > 1) ? $clog2(num_inp) : 1;
  endfunction

endpackage

// File: rtl/reqrsp_bank_tracker_fifo.sv
// In-order tag store: a wrapping-pointer FIFO with an occupancy count; no fall-through.
module reqrsp_bank_tracker_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [Width-1:0]               data_i,
  input  logic                           pop_i,
  output logic [Width-1:0]               data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(Depth+1)-1:0]     usage_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Tag contents need no reset; the count decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/reqrsp_bank_tracker.sv
// Per-bank stage: forwards requests, remembers the issuing requester in order, and tags
// each bank response with it so the crossbar can route it back.
module reqrsp_bank_tracker
  import reqrsp_bank_tracker_pkg::*;
#(
  parameter int unsigned NumInp         = 32'd0,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter type tcdm_req_chan_t        = logic,
  parameter type tcdm_rsp_chan_t        = logic,
  parameter type mst_sel_t              = logic [idx_width(NumInp)-1:0]
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  tcdm_req_chan_t                        xbar_req_i,
  input  logic                                  xbar_req_valid_i,
  output logic                                  xbar_req_ready_o,
  input  mst_sel_t                              xbar_req_idx_i,
  output tcdm_rsp_chan_t                        xbar_rsp_o,
  output logic                                  xbar_rsp_valid_o,
  input  logic                                  xbar_rsp_ready_i,
  output mst_sel_t                              xbar_rsp_sel_o,
  output tcdm_req_chan_t                        bank_req_o,
  output logic                                  bank_req_valid_o,
  input  logic                                  bank_req_ready_i,
  input  tcdm_rsp_chan_t                        bank_rsp_i,
  input  logic                                  bank_rsp_valid_i,
  output logic                                  bank_rsp_ready_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  idle_o,
  output logic                                  err_unexpected_o
);

  localparam int unsigned IdxW = $bits(mst_sel_t);

  logic     push, pop, full, empty;
  mst_sel_t head;

  // Full/empty come from the registered count only: no ready bypass, no tag fall-through.
  assign bank_req_o       = xbar_req_i;
  assign bank_req_valid_o = xbar_req_valid_i && !full;
  assign xbar_req_ready_o = bank_req_ready_i && !full;
  assign push             = bank_req_valid_o && bank_req_ready_i;
  assign pop              = xbar_rsp_valid_o && xbar_rsp_ready_i;

  always_comb begin
    xbar_rsp_o = bank_rsp_i;
    if (empty) begin
      // Nothing outstanding: swallow the stray beat and flag it.
      xbar_rsp_valid_o = 1'b0;
      xbar_rsp_sel_o   = '0;
      bank_rsp_ready_o = 1'b1;
      err_unexpected_o = bank_rsp_valid_i;
    end else begin
      xbar_rsp_valid_o = bank_rsp_valid_i;
      xbar_rsp_sel_o   = head;
      bank_rsp_ready_o = xbar_rsp_ready_i;
      err_unexpected_o = 1'b0;
    end
  end

  assign idle_o = (outstanding_o == '0);

  reqrsp_bank_tracker_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (xbar_req_idx_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (outstanding_o)
  );

endmodule

// File: tb/tb_reqrsp_bank_tracker.sv
// Directed bench: stimulus queues expected tagged responses; a negedge monitor checks them.
module tb_reqrsp_bank_tracker;

  typedef struct packed {
    logic        drop;
    logic [2:0]  sel;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] xbar_req;
  logic        xbar_req_valid, xbar_req_ready;
  logic [2:0]  xbar_req_idx;
  logic [15:0] xbar_rsp;
  logic        xbar_rsp_valid, xbar_rsp_ready;
  logic [2:0]  xbar_rsp_sel;
  logic [15:0] bank_req;
  logic        bank_req_valid, bank_req_ready;
  logic [15:0] bank_rsp;
  logic        bank_rsp_valid, bank_rsp_ready;
  logic [1:0]  outstanding;
  logic        idle, err_unexpected;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  reqrsp_bank_tracker #(
    .NumInp          (8),
    .MaxOutstanding  (3),
    .tcdm_req_chan_t (logic [15:0]),
    .tcdm_rsp_chan_t (logic [15:0]),
    .mst_sel_t       (logic [2:0])
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .xbar_req_i       (xbar_req),
    .xbar_req_valid_i (xbar_req_valid),
    .xbar_req_ready_o (xbar_req_ready),
    .xbar_req_idx_i   (xbar_req_idx),
    .xbar_rsp_o       (xbar_rsp),
    .xbar_rsp_valid_o (xbar_rsp_valid),
    .xbar_rsp_ready_i (xbar_rsp_ready),
    .xbar_rsp_sel_o   (xbar_rsp_sel),
    .bank_req_o       (bank_req),
    .bank_req_valid_o (bank_req_valid),
    .bank_req_ready_i (bank_req_ready),
    .bank_rsp_i       (bank_rsp),
    .bank_rsp_valid_i (bank_rsp_valid),
    .bank_rsp_ready_o (bank_rsp_ready),
    .outstanding_o    (outstanding),
    .idle_o           (idle),
    .err_unexpected_o (err_unexpected)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] idx, input logic [15:0] data);
    xbar_req_valid = 1'b1;
    xbar_req_idx   = idx;
    xbar_req       = data;
  endtask

  task automatic rsp(input logic [15:0] data, input logic drop, input logic [2:0] sel);
    bank_rsp_valid = 1'b1;
    bank_rsp       = data;
    exp_q.push_back('{drop: drop, sel: sel, data: data});
  endtask

  // Monitor: every routed response or dropped beat consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((xbar_rsp_valid && xbar_rsp_ready) || err_unexpected) begin
        if (exp_q.size() == 0) begin
          check("rsp_without_expectation", 32'(xbar_rsp_sel), 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("rsp_dropped", 32'(err_unexpected), 32'(e.drop));
          if (!e.drop) begin
            check("rsp_sel", 32'(xbar_rsp_sel), 32'(e.sel));
            check("rsp_data", 32'(xbar_rsp), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] b2b_idx [3];
    b2b_idx = '{3'd2, 3'd7, 3'd1};
    rst_n = 1'b0;
    xbar_req = '0; xbar_req_valid = 1'b0; xbar_req_idx = '0;
    bank_req_ready = 1'b1; xbar_rsp_ready = 1'b1;
    bank_rsp = '0; bank_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outstanding", 32'(outstanding), 0);
    check("reset_idle", 32'(idle), 1);
    check("reset_req_ready", 32'(xbar_req_ready), 1);
    check("reset_rsp_valid", 32'(xbar_rsp_valid), 0);
    check("reset_err", 32'(err_unexpected), 0);
    rst_n = 1'b1;

    // Single transaction, bank answers three cycles after the push.
    step();
    req(3'd5, 16'ha5a5);
    #1;
    check("single_bank_req", 32'(bank_req), 32'ha5a5);
    check("single_bank_req_valid", 32'(bank_req_valid), 1);
    check("single_req_ready", 32'(xbar_req_ready), 1);
    step();
    xbar_req_valid = 1'b0;
    #1;
    check("single_outstanding_1", 32'(outstanding), 1);
    check("single_idle_0", 32'(idle), 0);
    step();
    step();
    rsp(16'h1111, 1'b0, 3'd5);
    #1;
    check("single_sel_live", 32'(xbar_rsp_sel), 5);
    step();
    bank_rsp_valid = 1'b0;
    #1;
    check("single_outstanding_0", 32'(outstanding), 0);
    check("single_idle_1", 32'(idle), 1);

    // Response in the push cycle has no tag yet and is dropped; the next one is routed.
    req(3'd6, 16'h0006);
    rsp(16'hbeef, 1'b1, 3'd0);
    #1;
    check("samecycle_err", 32'(err_unexpected), 1);
    step();
    xbar_req_valid = 1'b0;
    rsp(16'h6666, 1'b0, 3'd6);
    #1;
    check("samecycle_outstanding", 32'(outstanding), 1);
    check("samecycle_err_clear", 32'(err_unexpected), 0);
    check("samecycle_rsp_valid", 32'(xbar_rsp_valid), 1);
    step();
    bank_rsp_valid = 1'b0;
    #1;
    check("samecycle_drained", 32'(outstanding), 0);

    // Back-to-back pushes fill the 3-deep store; the next request stalls.
    for (int i = 0; i < 3; i++) begin
      req(b2b_idx[i], 16'h0100 + 16'(i));
      #1;
      check("b2b_req_ready", 32'(xbar_req_ready), 1);
      step();
    end
    req(3'd3, 16'h0103);
    #1;
    check("full_req_ready", 32'(xbar_req_ready), 0);
    check("full_bank_req_valid", 32'(bank_req_valid), 0);
    check("full_outstanding", 32'(outstanding), 3);
    step();

    // Pop while full does not free a slot in the same cycle.
    rsp(16'h2222, 1'b0, 3'd2);
    #1;
    check("fullpop_req_ready", 32'(xbar_req_ready), 0);
    step();
    bank_rsp_valid = 1'b0;
    #1;
    check("fullpop_outstanding_2", 32'(outstanding), 2);
    check("fullpop_req_ready_next", 32'(xbar_req_ready), 1);
    step();
    xbar_req_valid = 1'b0;
    #1;
    check("fullpop_outstanding_3", 32'(outstanding), 3);

    // Response backpressure holds the head tag and the count.
    xbar_rsp_ready = 1'b0;
    bank_rsp_valid = 1'b1;
    bank_rsp = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_bank_rsp_ready", 32'(bank_rsp_ready), 0);
      check("bp_head_sel", 32'(xbar_rsp_sel), 7);
      check("bp_outstanding", 32'(outstanding), 3);
      step();
    end
    xbar_rsp_ready = 1'b1;
    bank_rsp_valid = 1'b0;
    rsp(16'h7777, 1'b0, 3'd7);
    #1;
    check("bp_release_ready", 32'(bank_rsp_ready), 1);
    step();
    rsp(16'h0101, 1'b0, 3'd1);
    step();
    rsp(16'h0303, 1'b0, 3'd3);
    step();
    bank_rsp_valid = 1'b0;
    #1;
    check("order_outstanding_0", 32'(outstanding), 0);
    check("order_idle", 32'(idle), 1);

    // Stray response with nothing outstanding.
    rsp(16'hdead, 1'b1, 3'd0);
    #1;
    check("stray_bank_rsp_ready", 32'(bank_rsp_ready), 1);
    check("stray_rsp_valid", 32'(xbar_rsp_valid), 0);
    check("stray_err", 32'(err_unexpected), 1);
    check("stray_sel", 32'(xbar_rsp_sel), 0);
    step();
    bank_rsp_valid = 1'b0;
    #1;
    check("stray_err_pulse_end", 32'(err_unexpected), 0);
    check("stray_outstanding", 32'(outstanding), 0);

    // Reset mid-flight discards tags; the late response is dropped.
    req(3'd4, 16'h0404);
    step();
    req(3'd6, 16'h0606);
    step();
    xbar_req_valid = 1'b0;
    #1;
    check("midrst_outstanding_2", 32'(outstanding), 2);
    rst_n = 1'b0;
    #1;
    check("midrst_outstanding_0", 32'(outstanding), 0);
    check("midrst_idle", 32'(idle), 1);
    step();
    rst_n = 1'b1;
    step();
    rsp(16'h4444, 1'b1, 3'd0);
    #1;
    check("midrst_late_err", 32'(err_unexpected), 1);
    check("midrst_late_outstanding", 32'(outstanding), 0);
    step();
    bank_rsp_valid = 1'b0;
    step();
    step();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
